// File: rtl/cam_fill_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cam_fill_ctrl_pkg
//   Shared types and helpers for the CAM fill controller slice.
//   - state_t : controller FSM states
//   - slot_w  : number of bits needed to index a CAM of a given depth
// ----------------------------------------------------------------------------
package cam_fill_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOOK  = 3'd1,
      ST_MEM   = 3'd2,
      ST_FILL  = 3'd3,
      ST_RESP  = 3'd4,
      ST_FLUSH = 3'd5
   } state_t;

   // Slot-index width; a single-entry CAM still needs one address bit.
   function automatic int slot_w(input int words);
      int w;
      if (words > 1) begin
         w = $clog2(words);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/cam_fill_ctrl_if.sv
// ----------------------------------------------------------------------------
// cam_fill_ctrl_if
//   Request/response handshake between a lookup client and cam_fill_ctrl.
//   master : the client (drives req_valid/req_tag/resp_ready)
//   slave  : the controller (drives req_ready/resp_valid/resp_data/resp_hit)
// ----------------------------------------------------------------------------
interface cam_fill_ctrl_if #(
   parameter int BITS   = 8,
   parameter int TAG_SZ = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [TAG_SZ-1:0] req_tag;
   logic              resp_valid;
   logic              resp_ready;
   logic [BITS-1:0]   resp_data;
   logic              resp_hit;

   modport master (
      output req_valid, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_hit
   );

   modport slave (
      input  req_valid, req_tag, resp_ready,
      output req_ready, resp_valid, resp_data, resp_hit
   );
endinterface

// File: rtl/cam_fill_ctrl_victim_sel.sv
// ----------------------------------------------------------------------------
// cam_victim_sel
//   Picks the CAM slot to fill on a miss.
//   valid_mask : shadow copy of the CAM valid bits
//   rr_ptr     : round-robin pointer used once every slot is valid
//   victim     : lowest-index invalid slot, or rr_ptr when all are valid
//   all_valid  : every slot is valid, i.e. the fill is an eviction
// ----------------------------------------------------------------------------
module cam_victim_sel
   import cam_fill_ctrl_pkg::*;
#(
   parameter int WORDS = 8,
   parameter int AW    = slot_w(WORDS)
) (
   input  logic [WORDS-1:0] valid_mask,
   input  logic [AW-1:0]    rr_ptr,
   output logic [AW-1:0]    victim,
   output logic             all_valid
);

   // Priority encoder: scanning downward leaves the lowest clear bit as the winner.
   always_comb begin
      victim    = rr_ptr;
      all_valid = &valid_mask;
      for (int i = WORDS - 1; i >= 0; i--) begin
         victim = valid_mask[i] ? victim : AW'(i);
      end
   end

endmodule

// File: rtl/cam_fill_ctrl.sv
// ----------------------------------------------------------------------------
// cam_fill_ctrl
//   Request-side controller in front of a tag CAM. Looks a tag up; on a hit
//   returns the CAM data, on a miss fetches from backing memory, writes the
//   line into a victim slot and returns the fetched data. A flush pulse
//   invalidates every entry, one slot per cycle.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : req_valid/req_ready/req_tag, resp_valid/resp_ready/
//                     resp_data/resp_hit
//   flush           : one-cycle request to invalidate all entries
//   flush_done      : one-cycle pulse after the last entry is cleared
//   cam_*           : lookup (check_tag/read/data/found_it) and write
//                     (write_/w_addr/wdata/new_tag/new_valid) CAM ports
//   mem_*           : backing-memory request (req/tag) and reply (ack/rdata)
// ----------------------------------------------------------------------------
module cam_fill_ctrl
   import cam_fill_ctrl_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = slot_w(WORDS) - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   cam_fill_ctrl_if.slave       bus,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [TAG_SZ-1:0]    cam_check_tag,
   output logic                 cam_read,
   input  logic [BITS-1:0]      cam_data,
   input  logic                 cam_found_it,
   output logic                 cam_write_,
   output logic [ADDR_LEFT:0]   cam_w_addr,
   output logic [BITS-1:0]      cam_wdata,
   output logic [TAG_SZ-1:0]    cam_new_tag,
   output logic                 cam_new_valid,
   output logic                 mem_req,
   output logic [TAG_SZ-1:0]    mem_tag,
   input  logic                 mem_ack,
   input  logic [BITS-1:0]      mem_rdata
);

   localparam int            AW        = ADDR_LEFT + 1;
   localparam logic [AW-1:0] LAST_SLOT = AW'(WORDS - 1);

   state_t              state_r;
   logic [TAG_SZ-1:0]   tag_r;
   logic [BITS-1:0]     data_r;
   logic                hit_r;
   logic [WORDS-1:0]    valid_r;
   logic [AW-1:0]       rr_ptr_r;
   logic                flush_pend_r;
   logic [AW-1:0]       cnt_r;
   logic                evict_r;

   logic                req_ready_r;
   logic                resp_valid_r;
   logic                flush_done_r;
   logic                cam_read_r;
   logic                cam_write_n_r;
   logic [AW-1:0]       cam_w_addr_r;
   logic [BITS-1:0]     cam_wdata_r;
   logic [TAG_SZ-1:0]   cam_new_tag_r;
   logic                cam_new_valid_r;
   logic                mem_req_r;

   logic [AW-1:0]       victim_s;
   logic                all_valid_s;

   cam_victim_sel #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_victim_sel (
      .valid_mask (valid_r),
      .rr_ptr     (rr_ptr_r),
      .victim     (victim_s),
      .all_valid  (all_valid_s)
   );

   // Controller FSM; every output is a register loaded on entry to the state that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         tag_r           <= {TAG_SZ{1'b0}};
         data_r          <= {BITS{1'b0}};
         hit_r           <= 1'b0;
         valid_r         <= {WORDS{1'b0}};
         rr_ptr_r        <= {AW{1'b0}};
         flush_pend_r    <= 1'b0;
         cnt_r           <= {AW{1'b0}};
         evict_r         <= 1'b0;
         req_ready_r     <= 1'b1;
         resp_valid_r    <= 1'b0;
         flush_done_r    <= 1'b0;
         cam_read_r      <= 1'b0;
         cam_write_n_r   <= 1'b1;
         cam_w_addr_r    <= {AW{1'b0}};
         cam_wdata_r     <= {BITS{1'b0}};
         cam_new_tag_r   <= {TAG_SZ{1'b0}};
         cam_new_valid_r <= 1'b0;
         mem_req_r       <= 1'b0;
      end else begin
         flush_done_r <= 1'b0;
         // A flush seen while busy is remembered and run on the next visit to IDLE.
         if (flush && (state_r != ST_IDLE)) begin
            flush_pend_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               // A flush beats a request arriving in the same cycle; the
               // client keeps req_valid up and is accepted after the flush.
               if (flush || flush_pend_r) begin
                  state_r         <= ST_FLUSH;
                  req_ready_r     <= 1'b0;
                  cnt_r           <= {AW{1'b0}};
                  cam_write_n_r   <= 1'b0;
                  cam_w_addr_r    <= {AW{1'b0}};
                  cam_wdata_r     <= {BITS{1'b0}};
                  cam_new_tag_r   <= {TAG_SZ{1'b0}};
                  cam_new_valid_r <= 1'b0;
               end else if (bus.req_valid && req_ready_r) begin
                  state_r     <= ST_LOOK;
                  tag_r       <= bus.req_tag;
                  cam_read_r  <= 1'b1;
                  req_ready_r <= 1'b0;
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            ST_LOOK: begin
               cam_read_r <= 1'b0;
               if (cam_found_it) begin
                  data_r       <= cam_data;
                  hit_r        <= 1'b1;
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_RESP;
               end else begin
                  mem_req_r <= 1'b1;
                  state_r   <= ST_MEM;
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  mem_req_r       <= 1'b0;
                  data_r          <= mem_rdata;
                  hit_r           <= 1'b0;
                  cam_write_n_r   <= 1'b0;
                  cam_w_addr_r    <= victim_s;
                  cam_wdata_r     <= mem_rdata;
                  cam_new_tag_r   <= tag_r;
                  cam_new_valid_r <= 1'b1;
                  evict_r         <= all_valid_s;
                  state_r         <= ST_FILL;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            ST_FILL: begin
               cam_write_n_r          <= 1'b1;
               valid_r[cam_w_addr_r]  <= 1'b1;
               // Round-robin only moves when a valid line was overwritten.
               if (evict_r) begin
                  rr_ptr_r <= (rr_ptr_r == LAST_SLOT) ? {AW{1'b0}} : rr_ptr_r + AW'(1);
               end else begin
                  rr_ptr_r <= rr_ptr_r;
               end
               resp_valid_r <= 1'b1;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= ~(flush_pend_r | flush);
                  state_r      <= ST_IDLE;
               end else begin
                  resp_valid_r <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (cnt_r == LAST_SLOT) begin
                  // A flush arriving during the final sweep cycle is already covered.
                  cam_write_n_r <= 1'b1;
                  valid_r       <= {WORDS{1'b0}};
                  rr_ptr_r      <= {AW{1'b0}};
                  flush_pend_r  <= 1'b0;
                  flush_done_r  <= 1'b1;
                  req_ready_r   <= 1'b1;
                  state_r       <= ST_IDLE;
               end else begin
                  cnt_r        <= cnt_r + AW'(1);
                  cam_w_addr_r <= cnt_r + AW'(1);
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               req_ready_r   <= 1'b1;
               resp_valid_r  <= 1'b0;
               cam_read_r    <= 1'b0;
               cam_write_n_r <= 1'b1;
               mem_req_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = data_r;
   assign bus.resp_hit   = hit_r;
   assign flush_done     = flush_done_r;
   assign cam_check_tag  = tag_r;
   assign cam_read       = cam_read_r;
   assign cam_write_     = cam_write_n_r;
   assign cam_w_addr     = cam_w_addr_r;
   assign cam_wdata      = cam_wdata_r;
   assign cam_new_tag    = cam_new_tag_r;
   assign cam_new_valid  = cam_new_valid_r;
   assign mem_req        = mem_req_r;
   assign mem_tag        = tag_r;

endmodule
